// File: rtl/iob_cache_be_arbiter.sv
// Back-end IOb arbiter: WTB write drain has priority over line refill; IOB_CACHE_BE_ARB_PERF_EN adds stall counters.
// Latency: 3 cycles per write, 2 per refill word at zero wait; stalls on be_ready_i/be_rvalid_i, refill is atomic.
module iob_cache_be_arbiter #(
    parameter int FE_ADDR_W     = 24,
    parameter int FE_DATA_W     = 32,
    parameter int BE_ADDR_W     = 24,
    parameter int WORD_OFFSET_W = 3,
    localparam int NBYTES       = FE_DATA_W / 8
) (
    input  logic                                 clk_i,
    input  logic                                 arst_i,
    input  logic                                 wtb_empty_i,
    input  logic [FE_ADDR_W+FE_DATA_W+NBYTES-1:0] wtb_data_i,
    output logic                                 wtb_read_o,
    input  logic                                 refill_req_i,
    input  logic [BE_ADDR_W-1:0]                 refill_addr_i,
    output logic                                 refill_valid_o,
    output logic [WORD_OFFSET_W-1:0]             refill_word_o,
    output logic [FE_DATA_W-1:0]                 refill_data_o,
    output logic                                 refill_done_o,
    output logic                                 be_avalid_o,
    output logic [BE_ADDR_W-1:0]                 be_addr_o,
    output logic [FE_DATA_W-1:0]                 be_wdata_o,
    output logic [NBYTES-1:0]                    be_wstrb_o,
    input  logic                                 be_ready_i,
    input  logic                                 be_rvalid_i,
    input  logic [FE_DATA_W-1:0]                 be_rdata_i,
    output logic                                 busy_o
`ifdef IOB_CACHE_BE_ARB_PERF_EN
    ,
    input  logic                                 cnt_clr_i,
    output logic [31:0]                          wr_stall_cnt_o,
    output logic [31:0]                          rd_stall_cnt_o
`endif
);

    localparam int BOFF_W = $clog2(NBYTES);
    localparam int WTB_W  = FE_ADDR_W + FE_DATA_W + NBYTES;
    localparam logic [WORD_OFFSET_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {IDLE, WR_POP, WR_LOAD, WR_REQ, RD_REQ, RD_WAIT} state_t;

    state_t                   state_q, state_d;
    logic [WORD_OFFSET_W-1:0] cnt_q, cnt_d;
    logic                     wtb_read_q, wtb_read_d;
    logic                     avalid_q, avalid_d;
    logic [BE_ADDR_W-1:0]     addr_q, addr_d;
    logic [FE_DATA_W-1:0]     wdata_q, wdata_d;
    logic [NBYTES-1:0]        wstrb_q, wstrb_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     rd_beat;
    logic                     rd_last;

    always_comb begin
        rd_beat  = (state_q == RD_WAIT) && be_rvalid_i;
        rd_last  = rd_beat && (cnt_q == CNT_MAX);
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        case (state_q)
            IDLE: begin
                // done_q masks a request still held high in the cycle after refill_done_o
                if (!wtb_empty_i) begin
                    state_d = WR_POP;
                end else if (refill_req_i && !done_q) begin
                    state_d = RD_REQ;
                    cnt_d   = '0;
                    addr_d  = refill_addr_i;
                    wdata_d = '0;
                    wstrb_d = '0;
                end
            end
            WR_POP:  state_d = WR_LOAD;
            WR_LOAD: begin
                state_d = WR_REQ;
                addr_d  = BE_ADDR_W'(wtb_data_i[WTB_W-1 -: FE_ADDR_W]);
                wdata_d = wtb_data_i[NBYTES +: FE_DATA_W];
                wstrb_d = wtb_data_i[NBYTES-1:0];
            end
            WR_REQ: begin
                if (be_ready_i) state_d = IDLE;
            end
            RD_REQ: begin
                if (be_ready_i) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (rd_beat) begin
                    cnt_d = cnt_q + WORD_OFFSET_W'(1);
                    if (rd_last) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RD_REQ;
                        addr_d  = refill_addr_i
                                + (BE_ADDR_W'(cnt_q + WORD_OFFSET_W'(1)) << BOFF_W);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        wtb_read_d = (state_d == WR_POP);
        avalid_d   = (state_d == WR_REQ) || (state_d == RD_REQ);
        busy_d     = (state_d != IDLE);
        done_d     = rd_last;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wtb_read_q <= 1'b0;
            avalid_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wtb_read_q <= wtb_read_d;
            avalid_q   <= avalid_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign wtb_read_o  = wtb_read_q;
    assign be_avalid_o = avalid_q;
    assign be_addr_o   = addr_q;
    assign be_wdata_o  = wdata_q;
    assign be_wstrb_o  = wstrb_q;
    assign busy_o      = busy_q;

    // Refill response is forwarded in the same cycle as be_rvalid_i, zeroed otherwise.
    assign refill_valid_o = rd_beat;
    assign refill_done_o  = rd_last;
    assign refill_word_o  = rd_beat ? cnt_q : '0;
    assign refill_data_o  = rd_beat ? be_rdata_i : '0;

`ifdef IOB_CACHE_BE_ARB_PERF_EN
    logic [31:0] wr_stall_q, wr_stall_d;
    logic [31:0] rd_stall_q, rd_stall_d;
    logic        wr_stall_inc;
    logic        rd_stall_inc;

    always_comb begin
        wr_stall_inc = refill_req_i && ((state_q inside {WR_POP, WR_LOAD, WR_REQ})
                                        || ((state_q == IDLE) && !wtb_empty_i));
        rd_stall_inc = (state_q == RD_WAIT) && !be_rvalid_i;
        wr_stall_d   = wr_stall_q;
        rd_stall_d   = rd_stall_q;
        if (cnt_clr_i) begin
            wr_stall_d = '0;
            rd_stall_d = '0;
        end else begin
            if (wr_stall_inc && (wr_stall_q != '1)) wr_stall_d = wr_stall_q + 32'd1;
            if (rd_stall_inc && (rd_stall_q != '1)) rd_stall_d = rd_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_stall_q <= '0;
            rd_stall_q <= '0;
        end else begin
            wr_stall_q <= wr_stall_d;
            rd_stall_q <= rd_stall_d;
        end
    end

    assign wr_stall_cnt_o = wr_stall_q;
    assign rd_stall_cnt_o = rd_stall_q;
`endif

endmodule

// File: tb/tb_iob_cache_be_arbiter.sv
// Directed bench for iob_cache_be_arbiter: WTB/back-end models with scoreboards of expected requests and refill words.
// Checks are immediate assertions; summary reports passed/total.
module tb_iob_cache_be_arbiter;

    logic        clk;
    logic        arst_i;
    logic        wtb_empty_i;
    logic [59:0] wtb_data_i;
    logic        wtb_read_o;
    logic        refill_req_i;
    logic [23:0] refill_addr_i;
    logic        refill_valid_o;
    logic [2:0]  refill_word_o;
    logic [31:0] refill_data_o;
    logic        refill_done_o;
    logic        be_avalid_o;
    logic [23:0] be_addr_o;
    logic [31:0] be_wdata_o;
    logic [3:0]  be_wstrb_o;
    logic        be_ready_i;
    logic        be_rvalid_i;
    logic [31:0] be_rdata_i;
    logic        busy_o;
`ifdef IOB_CACHE_BE_ARB_PERF_EN
    logic        cnt_clr_i;
    logic [31:0] wr_stall_cnt_o;
    logic [31:0] rd_stall_cnt_o;
`endif

    iob_cache_be_arbiter #(
        .FE_ADDR_W(24), .FE_DATA_W(32), .BE_ADDR_W(24), .WORD_OFFSET_W(3)
    ) dut (
        .clk_i(clk), .arst_i(arst_i),
        .wtb_empty_i(wtb_empty_i), .wtb_data_i(wtb_data_i), .wtb_read_o(wtb_read_o),
        .refill_req_i(refill_req_i), .refill_addr_i(refill_addr_i),
        .refill_valid_o(refill_valid_o), .refill_word_o(refill_word_o),
        .refill_data_o(refill_data_o), .refill_done_o(refill_done_o),
        .be_avalid_o(be_avalid_o), .be_addr_o(be_addr_o), .be_wdata_o(be_wdata_o),
        .be_wstrb_o(be_wstrb_o), .be_ready_i(be_ready_i), .be_rvalid_i(be_rvalid_i),
        .be_rdata_i(be_rdata_i), .busy_o(busy_o)
`ifdef IOB_CACHE_BE_ARB_PERF_EN
        , .cnt_clr_i(cnt_clr_i), .wr_stall_cnt_o(wr_stall_cnt_o), .rd_stall_cnt_o(rd_stall_cnt_o)
`endif
    );

    typedef struct packed {
        logic        rd;
        logic [23:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } be_exp_t;

    typedef struct packed {
        logic [2:0]  word;
        logic [31:0] data;
        logic        done;
    } rf_exp_t;

    be_exp_t     exp_be[$];
    rf_exp_t     exp_rf[$];
    logic [59:0] wtb_q[$];

    int          n_chk, n_pass, n_fail;
    int          cfg_wait, cfg_lat, wait_left, rd_lat;
    logic        rd_pend, drop_next;
    logic [23:0] rd_addr;
    int          n_pop, n_avalid, n_done, cyc, done_cyc, pop_cyc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // WTB FIFO and back-end slave models plus scoreboard comparisons, all mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (drop_next) begin
                refill_req_i = 1'b0;
                drop_next    = 1'b0;
            end
            if (arst_i) begin
                rd_pend     = 1'b0;
                be_ready_i  = 1'b0;
                be_rvalid_i = 1'b0;
                drop_next   = 1'b0;
                wait_left   = cfg_wait;
            end else begin
                if (wtb_read_o) begin
                    n_pop++;
                    pop_cyc = cyc;
                    check("wtb_pop_nonempty", 64'(wtb_q.size() > 0), 64'd1);
                    if (wtb_q.size() > 0) wtb_data_i = wtb_q.pop_front();
                    wtb_empty_i = (wtb_q.size() == 0);
                end
                be_rvalid_i = 1'b0;
                if (rd_pend) begin
                    if (rd_lat == 0) begin
                        be_rvalid_i = 1'b1;
                        be_rdata_i  = 32'h100 + 32'(rd_addr[4:2]);
                        rd_pend     = 1'b0;
                    end else begin
                        rd_lat--;
                    end
                end
                if (!be_avalid_o) begin
                    wait_left  = cfg_wait;
                    be_ready_i = 1'b0;
                end else begin
                    n_avalid++;
                    if (wait_left == 0) be_ready_i = 1'b1;
                    else begin
                        wait_left--;
                        be_ready_i = 1'b0;
                    end
                end
                #1;
                if (be_avalid_o && !be_ready_i && exp_be.size() > 0)
                    check("be_addr_hold", 64'(be_addr_o), 64'(exp_be[0].addr));
                if (be_avalid_o && be_ready_i) begin
                    check("be_req_expected", 64'(exp_be.size() > 0), 64'd1);
                    if (exp_be.size() > 0) begin
                        be_exp_t e;
                        e = exp_be.pop_front();
                        check("be_addr", 64'(be_addr_o), 64'(e.addr));
                        check("be_wstrb", 64'(be_wstrb_o), 64'(e.wstrb));
                        if (!e.rd) check("be_wdata", 64'(be_wdata_o), 64'(e.wdata));
                    end
                    if (be_wstrb_o == 4'h0) begin
                        rd_pend = 1'b1;
                        rd_lat  = cfg_lat;
                        rd_addr = be_addr_o;
                    end
                end
                if (refill_valid_o) begin
                    check("rf_expected", 64'(exp_rf.size() > 0), 64'd1);
                    if (exp_rf.size() > 0) begin
                        rf_exp_t r;
                        r = exp_rf.pop_front();
                        check("rf_word", 64'(refill_word_o), 64'(r.word));
                        check("rf_data", 64'(refill_data_o), 64'(r.data));
                        check("rf_done", 64'(refill_done_o), 64'(r.done));
                    end
                end
                if (refill_done_o) begin
                    n_done++;
                    done_cyc  = cyc;
                    drop_next = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_wr(input logic [23:0] a, input logic [31:0] d, input logic [3:0] s);
        be_exp_t e;
        wtb_q.push_back({a, d, s});
        wtb_empty_i = 1'b0;
        e.rd = 1'b0; e.addr = a; e.wdata = d; e.wstrb = s;
        exp_be.push_back(e);
    endtask

    task automatic exp_refill(input logic [23:0] base, input int nreq, input int nret);
        be_exp_t e;
        rf_exp_t r;
        for (int i = 0; i < nreq; i++) begin
            e.rd = 1'b1; e.addr = base + 24'(4 * i); e.wdata = '0; e.wstrb = 4'h0;
            exp_be.push_back(e);
        end
        for (int i = 0; i < nret; i++) begin
            r.word = 3'(i); r.data = 32'h100 + 32'(i); r.done = (i == 7);
            exp_rf.push_back(r);
        end
    endtask

    task automatic wait_idle(input string tag, input int max);
        int k;
        k = 0;
        step();
        while (k < max && !(!busy_o && wtb_empty_i && exp_be.size() == 0
                            && exp_rf.size() == 0 && !refill_req_i)) begin
            step();
            k++;
        end
        check(tag, 64'(k < max), 64'd1);
    endtask

    task automatic wait_for(input string tag, input logic [23:0] a, input logic want_avalid, input int max);
        int k;
        k = 0;
        while (k < max && !(busy_o && be_avalid_o == want_avalid && be_addr_o == a)) begin
            step();
            k++;
        end
        check(tag, 64'(k < max), 64'd1);
    endtask

    initial begin
        n_chk = 0; n_pass = 0; n_fail = 0;
        arst_i = 1'b1; wtb_empty_i = 1'b1; wtb_data_i = '0;
        refill_req_i = 1'b0; refill_addr_i = '0;
        be_ready_i = 1'b0; be_rvalid_i = 1'b0; be_rdata_i = '0;
        cfg_wait = 0; cfg_lat = 0; wait_left = 0; rd_lat = 0; rd_pend = 1'b0; rd_addr = '0;
        drop_next = 1'b0; n_pop = 0; n_avalid = 0; n_done = 0; cyc = 0; done_cyc = 0; pop_cyc = 0;
`ifdef IOB_CACHE_BE_ARB_PERF_EN
        cnt_clr_i = 1'b0;
`endif
        repeat (3) step();
        check("rst_avalid", 64'(be_avalid_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_wtb_read", 64'(wtb_read_o), 64'd0);
        check("rst_addr", 64'(be_addr_o), 64'd0);
        check("rst_wstrb", 64'(be_wstrb_o), 64'd0);
        check("rst_refill_valid", 64'(refill_valid_o), 64'd0);
        arst_i = 1'b0;
        step();
        check("idle_busy", 64'(busy_o), 64'd0);

        // Single write with two back-end wait cycles.
        cfg_wait = 2; n_pop = 0; n_avalid = 0;
        push_wr(24'h000104, 32'hDEADBEEF, 4'hF);
        wait_idle("t1_complete", 50);
        check("t1_pops", 64'(n_pop), 64'd1);
        check("t1_avalid_cycles", 64'(n_avalid), 64'd3);
        check("t1_busy", 64'(busy_o), 64'd0);

        // Full refill, request held one cycle past done.
        cfg_wait = 0; cfg_lat = 0; n_done = 0;
        exp_refill(24'h000200, 8, 8);
        refill_addr_i = 24'h000200;
        refill_req_i  = 1'b1;
        wait_idle("t2_complete", 200);
        check("t2_done_pulses", 64'(n_done), 64'd1);

        // Three buffered writes (one with wstrb=0) race a refill request.
        n_pop = 0; n_done = 0;
        push_wr(24'h000010, 32'h11111111, 4'hF);
        push_wr(24'h000014, 32'h22222222, 4'h0);
        push_wr(24'h000018, 32'h33333333, 4'h3);
        exp_refill(24'h000200, 8, 8);
        refill_req_i = 1'b1;
        wait_idle("t3_complete", 300);
        check("t3_pops", 64'(n_pop), 64'd3);
        check("t3_done_pulses", 64'(n_done), 64'd1);

        // WTB fills during refill word 2: the pop waits for the refill to finish.
        n_pop = 0;
        exp_refill(24'h000200, 8, 8);
        refill_req_i = 1'b1;
        wait_for("t4_reach_word2", 24'h000208, 1'b1, 50);
        push_wr(24'h000300, 32'hCAFEF00D, 4'hF);
        wait_idle("t4_complete", 200);
        check("t4_pops", 64'(n_pop), 64'd1);
        check("t4_pop_after_done", 64'(pop_cyc - done_cyc), 64'd2);

        // Reset while waiting for word 4, then a fresh refill restarts at word 0.
        cfg_lat = 3;
        exp_refill(24'h000200, 5, 4);
        refill_req_i = 1'b1;
        wait_for("t5_reach_word4", 24'h000210, 1'b0, 100);
        arst_i = 1'b1;
        refill_req_i = 1'b0;
        #1;
        check("t5_rst_busy", 64'(busy_o), 64'd0);
        check("t5_rst_avalid", 64'(be_avalid_o), 64'd0);
        check("t5_rst_addr", 64'(be_addr_o), 64'd0);
        check("t5_rst_refill_valid", 64'(refill_valid_o), 64'd0);
        check("t5_sb_be_drained", 64'(exp_be.size()), 64'd0);
        check("t5_sb_rf_drained", 64'(exp_rf.size()), 64'd0);
        step(); step();
        arst_i = 1'b0;
        step();
        cfg_lat = 0; n_done = 0;
        exp_refill(24'h000200, 8, 8);
        refill_req_i = 1'b1;
        wait_idle("t5_restart_complete", 200);
        check("t5_done_pulses", 64'(n_done), 64'd1);

`ifdef IOB_CACHE_BE_ARB_PERF_EN
        cfg_wait = 0; cfg_lat = 1;
        cnt_clr_i = 1'b1;
        step();
        cnt_clr_i = 1'b0;
        check("p_clr_wr", 64'(wr_stall_cnt_o), 64'd0);
        check("p_clr_rd", 64'(rd_stall_cnt_o), 64'd0);
        push_wr(24'h000040, 32'hA5A5A5A5, 4'hF);
        push_wr(24'h000044, 32'h5A5A5A5A, 4'hF);
        exp_refill(24'h000200, 8, 8);
        step();
        refill_req_i = 1'b1;
        wait_idle("p_complete", 300);
        check("p_wr_stall", 64'(wr_stall_cnt_o), 64'd7);
        check("p_rd_stall", 64'(rd_stall_cnt_o), 64'd8);
        cnt_clr_i = 1'b1;
        step();
        cnt_clr_i = 1'b0;
        check("p_clr2_wr", 64'(wr_stall_cnt_o), 64'd0);
        check("p_clr2_rd", 64'(rd_stall_cnt_o), 64'd0);
`endif

        repeat (3) step();
        check("end_busy", 64'(busy_o), 64'd0);
        check("end_sb_be", 64'(exp_be.size()), 64'd0);
        check("end_sb_rf", 64'(exp_rf.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/iob_cache_be_arbiter.md
Name: iob_cache_be_arbiter

Overview:
- Sequences the cache back-end IOb master port between two requesters: write-through-buffer (WTB) drain and read-miss line refill.
- Pops the WTB FIFO and issues single-word writes; fetches a refill line word by word and returns each word to the data memory.
- Writes always drain before a refill starts, so a refill never reads data older than a buffered write.

Parameters:
- FE_ADDR_W, 24, front-end byte address width.
- FE_DATA_W, 32, word width; back-end data width equals FE_DATA_W.
- BE_ADDR_W, 24, back-end byte address width; must be >= FE_ADDR_W.
- WORD_OFFSET_W, 3, log2 of words per line.
- NBYTES (localparam), FE_DATA_W/8.

Ports:
- clk_i  in  1  clock
- arst_i  in  1  asynchronous active-high reset
- wtb_empty_i  in  1  WTB FIFO empty
- wtb_data_i  in  FE_ADDR_W+FE_DATA_W+NBYTES  FIFO read data {addr, wdata, wstrb}; valid the cycle after wtb_read_o
- wtb_read_o  out  1  FIFO pop strobe
- refill_req_i  in  1  level request; held high until refill_done_o
- refill_addr_i  in  BE_ADDR_W  line base byte address; low WORD_OFFSET_W+log2(NBYTES) bits are zero
- refill_valid_o  out  1  refill word valid
- refill_word_o  out  WORD_OFFSET_W  index of the returned word
- refill_data_o  out  FE_DATA_W  returned word
- refill_done_o  out  1  one-cycle pulse, coincident with the last refill_valid_o
- be_avalid_o  out  1  back-end request valid
- be_addr_o  out  BE_ADDR_W  back-end byte address
- be_wdata_o  out  FE_DATA_W  write data
- be_wstrb_o  out  NBYTES  byte strobes; 0 means read
- be_ready_i  in  1  request accepted
- be_rvalid_i  in  1  read data valid
- be_rdata_i  in  FE_DATA_W  read data
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; word counter 0; all outputs 0.
- State IDLE:
  - If !wtb_empty_i, go to WR_POP (writes have priority).
  - Else if refill_req_i, go to RD_REQ with word counter = 0.
- State WR_POP: wtb_read_o=1 for exactly one cycle, then WR_LOAD.
- State WR_LOAD: register wtb_data_i into addr/wdata/wstrb registers, then WR_REQ.
- State WR_REQ:
  - be_avalid_o=1, be_addr_o = zero-extended registered address, be_wdata_o/be_wstrb_o = registered values.
  - Outputs are held stable until be_ready_i.
  - On be_ready_i, go to IDLE; the arbitration is re-evaluated there.
  - A write with wstrb=0 is still issued, as a read; its rdata is ignored.
- State RD_REQ:
  - be_avalid_o=1, be_wstrb_o=0, be_addr_o = refill_addr_i + counter*NBYTES.
  - On be_ready_i, go to RD_WAIT.
- State RD_WAIT:
  - On be_rvalid_i: refill_valid_o=1 for one cycle, refill_data_o=be_rdata_i, refill_word_o=counter.
  - If counter is at its maximum (2**WORD_OFFSET_W-1): refill_done_o=1 in the same cycle, counter wraps to 0, go to IDLE.
  - Otherwise: counter+1, go to RD_REQ.
- be_rvalid_i in any state other than RD_WAIT is ignored.
- A refill is atomic: no WTB pops occur between its words, even if the WTB fills.
- Simultaneous !wtb_empty_i and refill_req_i in IDLE: write first, one word per IDLE visit, until the WTB is empty.
- Minimum cost: 3 cycles per write, 2 cycles per refill word (zero-wait back-end).
- refill_req_i dropped mid-refill: the refill still completes. A refill_req_i still high in the cycle after refill_done_o is ignored for one cycle.
- Reset mid-operation: immediate return to IDLE. A popped but unissued WTB entry is lost, which is acceptable because reset also clears the FIFO.

Optional Feature:
- Macro: IOB_CACHE_BE_ARB_PERF_EN.
- Defined:
  - Adds input cnt_clr_i (1) and outputs wr_stall_cnt_o (32) and rd_stall_cnt_o (32).
  - wr_stall_cnt_o counts cycles with refill_req_i high while the state is a WR_* state or IDLE with !wtb_empty_i.
  - rd_stall_cnt_o counts cycles in RD_WAIT without be_rvalid_i.
  - Both counters saturate at 2^32-1, clear synchronously on cnt_clr_i, and clear asynchronously on arst_i.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single write: WTB holds {addr=0x000104, data=0xDEADBEEF, wstrb=0xF}, ready after 2 wait cycles -> one wtb_read_o pulse; be_avalid_o held 3 cycles with addr 0x000104, wstrb 0xF; then IDLE, busy_o=0.
- Refill, WORD_OFFSET_W=3, refill_addr_i=0x000200, be_rdata_i = 0x100+i -> addresses 0x200, 0x204, ..., 0x21C in order; eight refill_valid_o with words 0..7 and data 0x100..0x107; refill_done_o only with word 7.
- Conflict: 3 WTB entries plus refill_req_i in the same cycle -> 3 back-end writes complete before the first read request to 0x200.
- WTB becomes non-empty during refill word 2 -> no wtb_read_o until after refill_done_o; the pop occurs in the cycle after the IDLE re-entry.
- arst_i pulsed while in RD_WAIT at word 4 -> all outputs 0 immediately; a new refill restarts at word 0 with address refill_addr_i.
- IOB_CACHE_BE_ARB_PERF_EN: refill blocked by 2 writes, zero-wait, 1 cycle latency -> wr_stall_cnt_o=7 and rd_stall_cnt_o=8 after the full refill; cnt_clr_i clears both to 0.
